// File: rtl/shift_drv_pkg.sv
// Shared types and helpers for the serial shift driver.
// State encoding and counter-width sizing.
package shift_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LATCH = 2'd2
  } state_e;

  // Bits needed to hold 0..n, never narrower than 1.
  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/shift_drv_sck_gen.sv
// SCK divider: SCK_DIV clk per half-period, idles low.
// Emits rise/fall strobes on the edge where sck toggles.
module shift_drv_sck_gen
  import shift_drv_pkg::*;
#(
  parameter int SCK_DIV = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  output logic sck,
  output logic rise,
  output logic fall
);

  localparam int DW = cnt_w(SCK_DIV);
  localparam logic [DW-1:0] DIV_LAST =
    DW'(SCK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sck_q, sck_d;
  logic          term;

  always_comb begin
    term  = en && (div_q == DIV_LAST);
    div_d = '0;
    sck_d = 1'b0;
    if (en) begin
      div_d = term ? '0 : div_q + 1'b1;
      sck_d = term ? ~sck_q : sck_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck  = sck_q;
  assign rise = term & ~sck_q;
  assign fall = term & sck_q;

endmodule

// File: rtl/serial_shift_driver.sv
// Multi-channel MSB-first shift driver with latch strobe.
// Optional auto re-send: define SHIFT_DRV_AUTO_REFRESH_EN.
module serial_shift_driver
  import shift_drv_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int CH          = 1,
  parameter int SCK_DIV     = 2,
  parameter int LATCH_CYC   = 2,
  parameter int REFRESH_CYC = 4096
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CH*WIDTH-1:0] pdata,
  output logic                sck,
  output logic [CH-1:0]       sdat,
  output logic                latch,
  output logic                clrn,
  output logic                busy,
  output logic                frame_done
);

  localparam int BW = cnt_w(WIDTH);
  localparam int LW = cnt_w(LATCH_CYC);
  localparam logic [BW-1:0] BIT_TOP =
    BW'(WIDTH - 1);
  localparam logic [LW-1:0] LAT_LAST =
    LW'(LATCH_CYC - 1);

  state_e state_q, state_d;

  logic [BW-1:0] bit_q, bit_d;
  logic [LW-1:0] lat_q, lat_d;

  logic in_ready_q, in_ready_d;
  logic latch_q, latch_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic clrn_q;

  logic accept;
  logic refresh_go;
  logic load, shift, to_latch;
  logic sck_fall, rise_unused;
  logic [CH*WIDTH-1:0] ld_data;

  assign accept = in_valid & in_ready_q;

  shift_drv_sck_gen #(
    .SCK_DIV(SCK_DIV)
  ) u_sck (
    .clk (clk),
    .rstn(rstn),
    .en  (state_q == ST_SHIFT),
    .sck (sck),
    .rise(rise_unused),
    .fall(sck_fall)
  );

`ifdef SHIFT_DRV_AUTO_REFRESH_EN
  localparam int RW = cnt_w(REFRESH_CYC);
  localparam logic [RW-1:0] REF_LAST =
    RW'(REFRESH_CYC - 1);

  logic [RW-1:0]       idle_q, idle_d;
  logic [CH*WIDTH-1:0] shadow_q, shadow_d;

  // A real accept in the expiry cycle beats the re-send.
  always_comb begin
    idle_d     = '0;
    shadow_d   = shadow_q;
    refresh_go = 1'b0;
    if (state_q == ST_IDLE) begin
      if (accept)
        shadow_d = pdata;
      else if (idle_q == REF_LAST)
        refresh_go = 1'b1;
      else
        idle_d = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      idle_q   <= '0;
      shadow_q <= '0;
    end else begin
      idle_q   <= idle_d;
      shadow_q <= shadow_d;
    end
  end

  assign ld_data = accept ? pdata : shadow_q;
`else
  localparam int REFRESH_UNUSED = REFRESH_CYC;
  assign refresh_go = 1'b0;
  assign ld_data    = pdata;
`endif

  always_comb begin
    state_d    = state_q;
    bit_d      = bit_q;
    lat_d      = lat_q;
    in_ready_d = 1'b0;
    latch_d    = latch_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load       = 1'b0;
    shift      = 1'b0;
    to_latch   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        in_ready_d = 1'b1;
        latch_d    = 1'b0;
        busy_d     = 1'b0;
        if (accept || refresh_go) begin
          load       = 1'b1;
          state_d    = ST_SHIFT;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
          bit_d      = BIT_TOP;
        end
      end
      ST_SHIFT: begin
        // Data moves only as sck falls.
        if (sck_fall) begin
          if (bit_q == '0) begin
            to_latch = 1'b1;
            state_d  = ST_LATCH;
            latch_d  = 1'b1;
            lat_d    = '0;
          end else begin
            shift = 1'b1;
            bit_d = bit_q - 1'b1;
          end
        end
      end
      ST_LATCH: begin
        if (lat_q == LAT_LAST) begin
          state_d    = ST_IDLE;
          latch_d    = 1'b0;
          busy_d     = 1'b0;
          done_d     = 1'b1;
          in_ready_d = 1'b1;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      bit_q      <= '0;
      lat_q      <= '0;
      in_ready_q <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      clrn_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_q      <= bit_d;
      lat_q      <= lat_d;
      in_ready_q <= in_ready_d;
      latch_q    <= latch_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      clrn_q     <= 1'b1;
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [WIDTH-1:0] sr_q, sr_d, sr_sh;
    logic             sd_q, sd_d;

    always_comb begin
      sr_sh = sr_q << 1;
      sr_d  = sr_q;
      sd_d  = sd_q;
      if (load) begin
        sr_d = ld_data[c*WIDTH +: WIDTH];
        sd_d = ld_data[c*WIDTH + WIDTH - 1];
      end else if (shift) begin
        sr_d = sr_sh;
        sd_d = sr_sh[WIDTH-1];
      end else if (to_latch) begin
        sd_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        sr_q <= '0;
        sd_q <= 1'b0;
      end else begin
        sr_q <= sr_d;
        sd_q <= sd_d;
      end
    end

    assign sdat[c] = sd_q;
  end

  assign in_ready   = in_ready_q;
  assign latch      = latch_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign clrn       = clrn_q;

endmodule

// File: tb/tb_serial_shift_driver.sv
// Bench for serial_shift_driver: two configurations,
// table vectors, random frames, reset and b2b sequences.
module tb_serial_shift_driver;

  localparam int AW = 8;
  localparam int AS = 1;
  localparam int AL = 2;
  localparam int BW = 4;
  localparam int BS = 3;
  localparam int BL = 1;
  localparam int RC = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic        drv_valid = 1'b0;
  logic [15:0] drv_d = '0;

  logic       a_valid, a_ready, a_sck, a_latch;
  logic       a_clrn, a_busy, a_done;
  logic [1:0] a_sdat;
  logic       b_valid, b_ready, b_sck, b_latch;
  logic       b_clrn, b_busy, b_done;
  logic [1:0] b_sdat;

  assign a_valid = drv_valid & ~sel;
  assign b_valid = drv_valid & sel;

  serial_shift_driver #(
    .WIDTH(AW), .CH(2), .SCK_DIV(AS),
    .LATCH_CYC(AL), .REFRESH_CYC(RC)
  ) u_a (
    .clk(clk), .rstn(rstn),
    .in_valid(a_valid), .in_ready(a_ready),
    .pdata(drv_d), .sck(a_sck), .sdat(a_sdat),
    .latch(a_latch), .clrn(a_clrn),
    .busy(a_busy), .frame_done(a_done)
  );

  serial_shift_driver #(
    .WIDTH(BW), .CH(2), .SCK_DIV(BS),
    .LATCH_CYC(BL), .REFRESH_CYC(RC)
  ) u_b (
    .clk(clk), .rstn(rstn),
    .in_valid(b_valid), .in_ready(b_ready),
    .pdata(drv_d[7:0]), .sck(b_sck), .sdat(b_sdat),
    .latch(b_latch), .clrn(b_clrn),
    .busy(b_busy), .frame_done(b_done)
  );

  logic       o_ready, o_sck, o_latch, o_busy, o_done;
  logic [1:0] o_sdat;
  always_comb begin
    o_ready = sel ? b_ready : a_ready;
    o_sck   = sel ? b_sck   : a_sck;
    o_latch = sel ? b_latch : a_latch;
    o_busy  = sel ? b_busy  : a_busy;
    o_done  = sel ? b_done  : a_done;
    o_sdat  = sel ? b_sdat  : a_sdat;
  end

  logic [1:0] a_bits[$];
  logic [1:0] b_bits[$];
  int a_lat = 0;
  int b_lat = 0;
  always @(posedge a_sck) a_bits.push_back(a_sdat);
  always @(posedge b_sck) b_bits.push_back(b_sdat);
  always @(posedge a_latch) a_lat <= a_lat + 1;
  always @(posedge b_latch) b_lat <= b_lat + 1;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h",
                  name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    drv_d = d;
    drv_valid = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (o_ready) begin
        ok = 1'b1;
        a_bits.delete();
        b_bits.delete();
      end
      tick();
    end
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  // Expected waveform from frame timing arithmetic.
  task automatic check_frame(
    input  logic [15:0] d,
    input  bit          hold,
    input  logic [15:0] d_next,
    output logic [7:0]  s0,
    output logic [7:0]  s1);
    int w, s, l, t, errs, lat0;
    logic [1:0] q[$];
    w = sel ? BW : AW;
    s = sel ? BS : AS;
    l = sel ? BL : AL;
    t = 2 * s * w;
    errs = 0;
    lat0 = sel ? b_lat : a_lat;
    if (hold) drv_d = d_next;
    else drv_valid = 1'b0;
    for (int k = 0; k <= t + l; k++) begin
      logic e_sck, e_lat, e_busy, e_done, e_rdy;
      logic [1:0] e_sd;
      int bi;
      if (k < t) begin
        bi = k / (2 * s);
        e_sck = (k % (2 * s)) >= s;
        e_lat = 1'b0; e_busy = 1'b1;
        e_done = 1'b0; e_rdy = 1'b0;
        e_sd = {d[w + w - 1 - bi], d[w - 1 - bi]};
      end else if (k < t + l) begin
        e_sck = 1'b0; e_lat = 1'b1; e_busy = 1'b1;
        e_done = 1'b0; e_rdy = 1'b0; e_sd = 2'b00;
      end else begin
        e_sck = 1'b0; e_lat = 1'b0; e_busy = 1'b0;
        e_done = 1'b1; e_rdy = 1'b1; e_sd = 2'b00;
      end
      if ({o_sck, o_latch, o_busy, o_done, o_ready,
           o_sdat} !==
          {e_sck, e_lat, e_busy, e_done, e_rdy, e_sd})
        errs++;
      if (k < t + l) tick();
    end
    chk("frame_wave", errs, 0);
    q = sel ? b_bits : a_bits;
    chk("frame_nbits", q.size(), w);
    s0 = '0;
    s1 = '0;
    foreach (q[i]) begin
      s0 = {s0[6:0], q[i][0]};
      s1 = {s1[6:0], q[i][1]};
    end
    chk("frame_latches",
        (sel ? b_lat : a_lat) - lat0, 1);
  endtask

  typedef struct {
    bit          sel;
    logic [15:0] d;
    logic [7:0]  e0;
    logic [7:0]  e1;
  } vec_t;

  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] s0, s1, e0, e1;
    logic [15:0] d;
    int lat0;
    int busy_seen;

    tbl[0] = '{0, 16'h00A5, 8'hA5, 8'h00};
    tbl[1] = '{1, 16'h003C, 8'h0C, 8'h03};
    tbl[2] = '{0, 16'hFF01, 8'h01, 8'hFF};
    tbl[3] = '{1, 16'h0096, 8'h06, 8'h09};
    tbl[4] = '{0, 16'h8001, 8'h01, 8'h80};

    repeat (3) tick();
    chk("rst_a", {a_sck, a_sdat, a_latch, a_clrn,
                  a_ready, a_busy, a_done}, 0);
    chk("rst_b", {b_sck, b_sdat, b_latch, b_clrn,
                  b_ready, b_busy, b_done}, 0);
    rstn = 1'b1;
    tick();
    chk("rel_a", {a_ready, a_clrn, a_busy}, 3'b110);
    chk("rel_b", {b_ready, b_clrn, b_busy}, 3'b110);

    foreach (tbl[i]) begin
      sel = tbl[i].sel;
      send(tbl[i].d);
      check_frame(tbl[i].d, 1'b0, 16'h0, s0, s1);
      chk("tbl_ch0", s0, tbl[i].e0);
      chk("tbl_ch1", s1, tbl[i].e1);
    end

    // Held in_valid during a frame: next accept right after done.
    sel = 1'b0;
    send(16'h1234);
    check_frame(16'h1234, 1'b1, 16'hBEEF, s0, s1);
    chk("b2b_f1_ch0", s0, 8'h34);
    chk("b2b_f1_ch1", s1, 8'h12);
    tick();
    chk("b2b_accept", {o_ready, o_busy}, 2'b01);
    a_bits.delete();
    check_frame(16'hBEEF, 1'b0, 16'h0, s0, s1);
    chk("b2b_f2_ch0", s0, 8'hEF);
    chk("b2b_f2_ch1", s1, 8'hBE);

    for (int i = 0; i < 12; i++) begin
      sel = (i % 3) == 2;
      d = 16'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      send(d);
      check_frame(d, 1'b0, 16'h0, s0, s1);
      e0 = sel ? {4'h0, d[3:0]} : d[7:0];
      e1 = sel ? {4'h0, d[7:4]} : d[15:8];
      chk("rnd_ch0", s0, e0);
      chk("rnd_ch1", s1, e1);
    end

    // Reset in the middle of bit 5.
    sel = 1'b0;
    send(16'h5AC3);
    drv_valid = 1'b0;
    repeat (10) tick();
    chk("pre_rst_busy", a_busy, 1);
    lat0 = a_lat;
    #2;
    rstn = 1'b0;
    #1;
    chk("rst_mid", {a_sck, a_sdat, a_latch, a_clrn,
                    a_ready, a_busy, a_done}, 0);
    repeat (3) tick();
    rstn = 1'b1;
    tick();
    chk("rst_rel", {a_ready, a_clrn, a_busy}, 3'b110);
    repeat (4) tick();
    chk("rst_no_latch", a_lat - lat0, 0);

`ifdef SHIFT_DRV_AUTO_REFRESH_EN
    sel = 1'b0;
    send(16'h0081);
    check_frame(16'h0081, 1'b0, 16'h0, s0, s1);
    repeat (15) tick();
    chk("ref_wait", a_busy, 0);
    a_bits.delete();
    tick();
    chk("ref_start", a_busy, 1);
    check_frame(16'h0081, 1'b0, 16'h0, s0, s1);
    chk("ref_ch0", s0, 8'h81);
    chk("ref_ch1", s1, 8'h00);
    repeat (15) tick();
    drv_d = 16'h00C3;
    drv_valid = 1'b1;
    a_bits.delete();
    tick();
    chk("ref_new_start", a_busy, 1);
    check_frame(16'h00C3, 1'b0, 16'h0, s0, s1);
    chk("ref_new_ch0", s0, 8'hC3);
`else
    sel = 1'b0;
    drv_valid = 1'b0;
    busy_seen = 0;
    repeat (40) begin
      tick();
      if (a_busy | b_busy) busy_seen++;
    end
    chk("no_refresh", busy_seen, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
